// File: rtl/bnn_pkg.sv
// Shared types and width helpers for the BNN stream loader slice.
package bnn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } bnn_state_e;

    localparam int unsigned DEF_IMG_DIM   = 28;
    localparam int unsigned DEF_KDIM      = 3;
    localparam int unsigned DEF_N_KERNELS = 8;
    localparam int unsigned DEF_LANES     = 1;

    function automatic int unsigned pix_bits(input int unsigned img_dim);
        return img_dim * img_dim;
    endfunction

    function automatic int unsigned w_bits(input int unsigned n_kernels, input int unsigned kdim);
        return n_kernels * kdim * kdim;
    endfunction

    // Counter must be able to hold the full value itself, hence depth+1.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    localparam int unsigned PIX_BITS = pix_bits(DEF_IMG_DIM);
    localparam int unsigned W_BITS   = w_bits(DEF_N_KERNELS, DEF_KDIM);

endpackage

// File: rtl/bnn_stream_loader_if.sv
// Streaming pixel/weight load bus plus loader status outputs.
interface bnn_stream_loader_if #(
    parameter int unsigned IMG_DIM   = bnn_pkg::DEF_IMG_DIM,
    parameter int unsigned KDIM      = bnn_pkg::DEF_KDIM,
    parameter int unsigned N_KERNELS = bnn_pkg::DEF_N_KERNELS,
    parameter int unsigned LANES     = bnn_pkg::DEF_LANES
);
    localparam int unsigned PIX_N = bnn_pkg::pix_bits(IMG_DIM);
    localparam int unsigned W_N   = bnn_pkg::w_bits(N_KERNELS, KDIM);

    logic             start;
    logic             valid_p;
    logic [LANES-1:0] d_in_p;
    logic             valid_w;
    logic [LANES-1:0] d_in_w;
    logic [PIX_N-1:0] pixels;
    logic [W_N-1:0]   weights;
    logic [1:0]       state;
    logic             load_done;
    logic             loaded;
    logic             overrun;

    modport master (
        output start, valid_p, d_in_p, valid_w, d_in_w,
        input  pixels, weights, state, load_done, loaded, overrun
    );

    modport slave (
        input  start, valid_p, d_in_p, valid_w, d_in_w,
        output pixels, weights, state, load_done, loaded, overrun
    );

endinterface

// File: rtl/bnn_lane_buffer.sv
// One load channel: shifts LANES bits per valid beat into a DEPTH-bit store.
module bnn_lane_buffer
    import bnn_pkg::*;
#(
    parameter int unsigned DEPTH = PIX_BITS,
    parameter int unsigned LANES = DEF_LANES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             valid,
    input  logic [LANES-1:0] d_in,
    output logic [DEPTH-1:0] store,
    output logic             full,
    output logic             overrun
);
    localparam int unsigned CW = cnt_width(DEPTH);

    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] store_q, store_d;
    logic             ovr_q, ovr_d;
    logic [DEPTH-1:0] lane_mask, lane_data;

    // Next-state: clear wins over data; beats on a full channel only raise overrun
    always_comb begin
        count_d   = count_q;
        store_d   = store_q;
        ovr_d     = ovr_q;
        lane_mask = DEPTH'({LANES{1'b1}}) << count_q;
        lane_data = DEPTH'(d_in) << count_q;
        if (clear) begin
            count_d = '0;
            ovr_d   = 1'b0;
        end else if (valid) begin
            if (count_q < CW'(DEPTH)) begin
                store_d = (store_q & ~lane_mask) | lane_data;
                count_d = count_q + CW'(LANES);
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    // Channel registers; store contents survive clear
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            store_q <= '0;
            ovr_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            store_q <= store_d;
            ovr_q   <= ovr_d;
        end
    end

    assign store   = store_q;
    assign full    = (count_q == CW'(DEPTH));
    assign overrun = ovr_q;

endmodule

// File: rtl/bnn_stream_loader.sv
// Loads one binary image and one kernel set from two independent bit streams.
module bnn_stream_loader
    import bnn_pkg::*;
#(
    parameter int unsigned IMG_DIM   = DEF_IMG_DIM,
    parameter int unsigned KDIM      = DEF_KDIM,
    parameter int unsigned N_KERNELS = DEF_N_KERNELS,
    parameter int unsigned LANES     = DEF_LANES
) (
    input logic                clk,
    input logic                rst,
    bnn_stream_loader_if.slave bus
);
    localparam int unsigned PIX_N = pix_bits(IMG_DIM);
    localparam int unsigned W_N   = w_bits(N_KERNELS, KDIM);

    if (((PIX_N % LANES) != 0) || ((W_N % LANES) != 0)) begin : g_bad_lanes
        $error("bnn_stream_loader: store sizes must be multiples of LANES");
    end

    bnn_state_e state_q, state_d;
    logic       stray_q, stray_d;
    logic       pix_full, w_full, pix_ovr, w_ovr;
    logic       lane_en, pix_valid, w_valid;
    logic       load_done_c, loaded_c;

    // Data is only taken in LOAD, and never in a cycle that restarts the load
    assign lane_en   = (state_q == ST_LOAD) && !bus.start;
    assign pix_valid = bus.valid_p && lane_en;
    assign w_valid   = bus.valid_w && lane_en;

    bnn_lane_buffer #(
        .DEPTH (PIX_N),
        .LANES (LANES)
    ) u_pix (
        .clk     (clk),
        .rst     (rst),
        .clear   (bus.start),
        .valid   (pix_valid),
        .d_in    (bus.d_in_p),
        .store   (bus.pixels),
        .full    (pix_full),
        .overrun (pix_ovr)
    );

    bnn_lane_buffer #(
        .DEPTH (W_N),
        .LANES (LANES)
    ) u_wgt (
        .clk     (clk),
        .rst     (rst),
        .clear   (bus.start),
        .valid   (w_valid),
        .d_in    (bus.d_in_w),
        .store   (bus.weights),
        .full    (w_full),
        .overrun (w_ovr)
    );

    // State register and the flag for data arriving outside LOAD
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            stray_q <= 1'b0;
        end else begin
            state_q <= state_d;
            stray_q <= stray_d;
        end
    end

    // Next-state: start always (re)enters LOAD; LOAD completes once both stores are full
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_LOAD;
            ST_LOAD: begin
                if (bus.start)               state_d = ST_LOAD;
                else if (pix_full && w_full) state_d = ST_DONE;
            end
            ST_DONE: if (bus.start) state_d = ST_LOAD;
            default: state_d = ST_IDLE;
        endcase
    end

    // Stray-data flag: cleared by start, set by any valid while not loading
    always_comb begin
        stray_d = stray_q;
        if (bus.start) begin
            stray_d = 1'b0;
        end else if ((bus.valid_p || bus.valid_w) && (state_q != ST_LOAD)) begin
            stray_d = 1'b1;
        end
    end

    // Outputs: load_done marks the LOAD->DONE cycle, loaded covers it and all of DONE
    always_comb begin
        load_done_c = 1'b0;
        loaded_c    = 1'b0;
        case (state_q)
            ST_LOAD: load_done_c = pix_full && w_full && !bus.start;
            ST_DONE: loaded_c    = 1'b1;
            default: ;
        endcase
        loaded_c = loaded_c || load_done_c;
    end

    assign bus.state     = state_q;
    assign bus.load_done = load_done_c;
    assign bus.loaded    = loaded_c;
    assign bus.overrun   = pix_ovr || w_ovr || stray_q;

endmodule
